// File: rtl/music_pkg.sv
`default_nettype none
// ============================================================================
// Module   : music_pkg
// Purpose  : Shared widths, constants and the packed per-voice state type
//            used by the note scheduler and its voice slots.
// Revision : 1.0  initial release
// ============================================================================
package music_pkg;

  // Number of simultaneously sounding voices
  localparam int NUM_VOICES = 3;
  // Width of a note index and of a duration in beats
  localparam int NOTE_W     = 6;
  // Width of the opaque per-note metadata
  localparam int META_W     = 3;

  // Note index that means "no sound"
  localparam logic [NOTE_W-1:0] NOTE_SILENCE = '0;

  // Complete state of one voice slot; all-zero is the idle state
  typedef struct packed {
    logic              active;
    logic [NOTE_W-1:0] remaining;
    logic [NOTE_W-1:0] note;
    logic [META_W-1:0] meta;
  } voice_state_t;

endpackage : music_pkg
`default_nettype wire

// File: rtl/voice_slot.sv
`default_nettype none
// ============================================================================
// Module   : voice_slot
// Purpose  : One voice of the scheduler. Holds the note, metadata and the
//            remaining-beat counter, and produces a one-cycle expire pulse
//            when the counter runs out naturally.
// Revision : 1.0  initial release
// ============================================================================
module voice_slot
  import music_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              dec,
  input  logic [NOTE_W-1:0] load_note,
  input  logic [NOTE_W-1:0] load_dur,
  input  logic [META_W-1:0] load_meta,
  output logic              active,
  output logic [NOTE_W-1:0] remaining,
  output logic [NOTE_W-1:0] note_q,
  output logic [META_W-1:0] meta_q,
  output logic              expire
);

  voice_state_t r_state;
  logic         r_expire;
  logic         w_last_beat;

  // This beat takes the counter from 1 to 0 (a load in the same cycle wins)
  assign w_last_beat = r_state.active && dec && (r_state.remaining == NOTE_W'(1));

  // Load has priority over countdown; decrement only while active so the
  // counter can never wrap below zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= '0;
      r_expire <= 1'b0;
    end else begin
      r_expire <= w_last_beat && !load;
      if (load) begin
        r_state.active    <= 1'b1;
        r_state.remaining <= load_dur;
        r_state.note      <= load_note;
        r_state.meta      <= load_meta;
      end else if (w_last_beat) begin
        r_state <= '0;
      end else if (r_state.active && dec) begin
        r_state.remaining <= r_state.remaining - 1'b1;
      end
    end
  end

  assign active    = r_state.active;
  assign remaining = r_state.remaining;
  assign note_q    = r_state.note;
  assign meta_q    = r_state.meta;
  assign expire    = r_expire;

endmodule : voice_slot
`default_nettype wire

// File: rtl/note_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : note_scheduler
// Purpose  : Three-voice note scheduler. Allocates each accepted new_note to
//            the lowest idle voice (or steals the voice closest to ending),
//            counts voices down on beat while playing, and reports per-voice
//            and whole-chord completion. All outputs are registered.
// Revision : 1.0  initial release
// ============================================================================
module note_scheduler #(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W     = 6,
  parameter int META_W     = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         play,
  input  logic                         beat,
  input  logic                         new_note,
  input  logic [NOTE_W-1:0]            note,
  input  logic [NOTE_W-1:0]            duration,
  input  logic [META_W-1:0]            metadata,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NUM_VOICES-1:0]        voice_load,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES*META_W-1:0] voice_meta,
  output logic [NUM_VOICES-1:0]        voice_done,
  output logic                         note_done
);

  import music_pkg::*;

  logic                  w_dec;
  logic                  w_accept;
  logic [NUM_VOICES-1:0] w_active;
  logic [NUM_VOICES-1:0] w_expire;
  logic [NUM_VOICES-1:0] w_load;
  logic [NUM_VOICES-1:0] w_exp_nxt;
  logic [NUM_VOICES-1:0] w_act_nxt;
  logic [NOTE_W-1:0]     w_rem [NUM_VOICES];
  logic                  w_found_idle;
  int                    w_idle_idx;
  int                    w_steal_idx;
  int                    w_pick;
  logic [NOTE_W-1:0]     w_best;
  logic                  w_note_done_nxt;

  logic [NUM_VOICES-1:0] r_load;
  logic                  r_note_done;

  // Counting is enabled only on a beat while playing
  assign w_dec = beat && play;

  // Silent or zero-length requests are dropped without any effect
  assign w_accept = new_note && (note != NOTE_SILENCE) && (duration != '0);

  // Allocator: lowest idle voice first, otherwise the voice with the smallest
  // remaining count (strict compare keeps ties on the lowest index). Idleness
  // uses pre-edge state, so a voice expiring this cycle still counts as busy.
  always_comb begin
    w_found_idle = 1'b0;
    w_idle_idx   = 0;
    w_steal_idx  = 0;
    w_best       = w_rem[0];
    w_pick       = 0;
    w_load       = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!w_active[i] && !w_found_idle) begin
        w_found_idle = 1'b1;
        w_idle_idx   = i;
      end
    end
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (w_rem[i] < w_best) begin
        w_best      = w_rem[i];
        w_steal_idx = i;
      end
    end
    w_pick = w_found_idle ? w_idle_idx : w_steal_idx;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (w_accept && (i == w_pick)) begin
        w_load[i] = 1'b1;
      end
    end
  end

  // Predict next-cycle activity to detect the chord ending by natural expiry;
  // a voice being reloaded never counts as expiring
  always_comb begin
    w_exp_nxt = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_exp_nxt[i] = w_active[i] && w_dec && (w_rem[i] == NOTE_W'(1)) && !w_load[i];
    end
    w_act_nxt       = (w_active & ~w_exp_nxt) | w_load;
    w_note_done_nxt = (|w_exp_nxt) && !(|w_act_nxt);
  end

  // Registered load strobe and chord-complete pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_load      <= '0;
      r_note_done <= 1'b0;
    end else begin
      r_load      <= w_load;
      r_note_done <= w_note_done_nxt;
    end
  end

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    voice_slot u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (w_load[gi]),
      .dec       (w_dec),
      .load_note (note),
      .load_dur  (duration),
      .load_meta (metadata),
      .active    (w_active[gi]),
      .remaining (w_rem[gi]),
      .note_q    (voice_note[gi*NOTE_W +: NOTE_W]),
      .meta_q    (voice_meta[gi*META_W +: META_W]),
      .expire    (w_expire[gi])
    );
  end

  assign voice_active = w_active;
  assign voice_load   = r_load;
  assign voice_done   = w_expire;
  assign note_done    = r_note_done;

endmodule : note_scheduler
`default_nettype wire

// File: doc/note_scheduler.md
# note_scheduler

Three-voice note scheduler between `song_reader_new` and the per-voice note players.
- Accepts each `new_note` pulse with its note, duration and metadata, and assigns it to a voice slot.
- Counts each voice's duration down on `beat`, and reports per-voice and whole-chord completion.
- Lets consecutive ROM notes read without an intervening rest sound simultaneously as a chord.

## Interface
Parameters:
- `NUM_VOICES`, 3: number of voice slots. Fixed at 3 for this revision.
- `NOTE_W`, 6: note and duration width.
- `META_W`, 3: metadata width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `play`  in  1  high: counting enabled; low: all counters frozen.
- `beat`  in  1  single-cycle 48 Hz tick.
- `new_note`  in  1  single-cycle request to schedule a note.
- `note`  in  6  note index; 0 is silence.
- `duration`  in  6  length in beats.
- `metadata`  in  3  timbre/flags; passed through per voice, not interpreted.
- `voice_active`  out  3  bit i high while voice i is sounding.
- `voice_load`  out  3  bit i pulses one cycle when voice i takes a new note.
- `voice_note`  out  18  `{v2,v1,v0}` note per voice; 0 when idle.
- `voice_meta`  out  9  `{v2,v1,v0}` metadata per voice; 0 when idle.
- `voice_done`  out  3  bit i pulses one cycle when voice i expires naturally.
- `note_done`  out  1  one-cycle pulse when the last active voice expires.

## Operation
Per-voice state: `active`, `remaining[5:0]`, `note_q`, `meta_q`.

Request filtering:
- A request with `note==0` or `duration==0` is dropped.
- A dropped request causes no state change and no `voice_load`.

Allocation on an accepted `new_note`:
- Use the lowest-index idle voice, if any.
- If no voice is idle, steal the active voice with the smallest `remaining`; ties go to the lowest index.
- The stolen voice gets no `voice_done` pulse.
- The chosen voice loads `remaining=duration`, `note_q=note`, `meta_q=metadata`, `active=1`.
- `voice_load[i]` pulses for that voice.

Countdown:
- On a cycle with `beat && play`, every active voice that is not being loaded that cycle decrements `remaining`.
- A voice decrementing from 1 to 0 goes idle and pulses `voice_done[i]`.
- Its `note_q` and `meta_q` clear to 0.

Chord completion:
- `note_done` pulses in the cycle in which `voice_active` goes from nonzero to zero because of natural expiry.
- Stealing never causes `note_done`.

Simultaneous events:
- If `new_note` and `beat` coincide, idleness is judged on pre-edge state. A voice expiring in that same cycle counts as busy.
- If that expiring voice is chosen for stealing, the load wins: no `voice_done`, no `note_done`, and the new duration is not decremented.
- If `new_note` arrives while `play==0`, the note is still allocated and loaded. Its countdown starts only once `play` is high.
- `remaining` never underflows. Loads overwrite; decrements are gated by `active`.

Reset behaviour: reset mid-operation drops all voices immediately. No done pulses are emitted.

## Timing
- All outputs are registered. Reset values are all zero: `voice_active`, `voice_load`, `voice_note`, `voice_meta`, `voice_done`, `note_done`.
- Load latency is 1 cycle. For `new_note` sampled at edge k, `voice_active[i]`, `voice_note` and `voice_load[i]` are valid in the cycle after edge k. `voice_load` deasserts after edge k+1.
- A note of duration D loaded at edge k expires on the D-th qualifying beat edge after k. `voice_done` is high for exactly the cycle following that edge.
- Back-to-back `new_note` on consecutive cycles is supported, one allocation per cycle.
- No backpressure: every accepted request is placed.

## Structure
Shared package `music_pkg`:
- `NUM_VOICES`, `NOTE_W`, `META_W`, `NOTE_SILENCE=0`.
- The packed voice-state typedef `{active, remaining, note, meta}`.

Sub-module `voice_slot`, instantiated `NUM_VOICES` times:
- Contains the counter and registers.
- Inputs: `load`, `dec`.
- Outputs: `active`, `remaining`, `expire`.

Top level contains the combinational allocator (idle priority encoder plus min-remaining compare) and the `note_done` logic.

## Test plan
- Reset asserted mid-chord with 3 voices active → all outputs 0 immediately, no `done` pulses; next `new_note` (5,4) loads voice 0.
- `new_note` (note 10, dur 3, meta 2) with `play=1` → `voice_load=001`, `voice_note[5:0]=10`; after 3 beats, `voice_done=001` and `note_done` both pulse once; `voice_active=000`.
- Three notes (durations 4, 2, 6) on consecutive cycles, then a fourth (dur 5) → fourth steals voice 1 (remaining 2), no `voice_done[1]`; voices end after 4, 5 and 6 beats; `note_done` pulses only at the last.
- `new_note` with `note=0`, and separately with `duration=0` → no load, outputs unchanged.
- `play=0` for 10 beats with voice 0 at remaining 2 → frozen; after resume, expires on the 2nd beat.
- All voices full, voice 2 at remaining 1; `new_note` coincides with `beat` → voice 2 reloaded with the new duration; no `voice_done`, no `note_done`; voices 0 and 1 decrement.
